// File: rtl/mem_access_unit.sv
// Initiator for a word-wide data RAM (async read, sync write): byte/halfword/word
// loads and stores, sub-word stores done as read-modify-write, misalignment flagged.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [1:0]            r_lane;
  logic [15:0]           r_wdata16;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_error;

  logic                  w_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_unused_addr;

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is in flight.
  // resp_valid is a one-cycle pulse and cannot be stalled.
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;
  assign mem_write  = (r_state == S_WRITE);
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign dbg_state  = r_state;

  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign w_err = (req_size == 2'b11) ||
                 ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Lane extraction and lane merge both work on the word the RAM returns in READ.
  always_comb begin
    w_byte   = mem_rdata[7:0];
    w_half   = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load   = mem_rdata;
    w_merged = mem_rdata;
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd1:    w_merged[15:8]  = r_wdata16[7:0];
        2'd2:    w_merged[23:16] = r_wdata16[7:0];
        2'd3:    w_merged[31:24] = r_wdata16[7:0];
        default: w_merged[7:0]   = r_wdata16[7:0];
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata16;
    end else begin
      w_merged[15:0] = r_wdata16;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata16    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      // Response fields are only set on the edge entering RESP, cleared otherwise.
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata16  <= req_wdata[15:0];
            if (w_err) begin
              r_resp_error <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_mem_addr <= req_addr[ADDR_WIDTH+1:2];
              if (req_we && (req_size == 2'b10)) begin
                r_mem_wdata <= req_wdata;
                r_state     <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (r_we) begin
            r_mem_wdata <= w_merged;
            r_state     <= S_WRITE;
          end else begin
            r_resp_rdata <= w_load;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-wide data RAM interface. The RAM has asynchronous read, synchronous write and is word-addressed.
- Accepts byte, halfword and word load/store requests from the MEM stage through a valid/ready handshake.
- Drives the RAM port. Sub-word stores are performed as read-modify-write.
- Returns sign- or zero-extended load data and flags misaligned accesses.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width; the RAM holds 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  00=byte, 01=halfword, 10=word, 11=reserved.
- req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  misaligned or reserved-size request; valid with resp_valid.
- mem_write  output  1  to RAM write enable.
- mem_addr  output  ADDR_WIDTH  to RAM word address.
- mem_wdata  output  32  to RAM write data.
- mem_rdata  input  32  from RAM asynchronous read data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE.
  - Registered request fields cleared.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the access: no write is issued after the reset edge and no response is produced.
- Handshake:
  - Accept when req_valid && req_ready at a rising edge.
  - All request fields are registered at accept; inputs are don't-care afterwards.
  - req_ready=1 only in IDLE. There is one outstanding request at a time.
  - resp_valid is a single-cycle pulse with no backpressure.
- Address mapping:
  - Word index = req_addr[ADDR_WIDTH+1:2]. req_addr[31:ADDR_WIDTH+2] is ignored, so addresses wrap modulo RAM size.
  - Byte lane = req_addr[1:0], little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
- Errors (detected at accept):
  - Halfword with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Next state is RESP with resp_error=1 and resp_rdata=0. mem_write is never asserted for an error request.
- States:
  - IDLE:
    - accept load, or sub-word store -> READ;
    - accept word store -> WRITE;
    - accept error -> RESP;
    - otherwise stay.
  - READ:
    - mem_addr = registered word index; capture mem_rdata into a word register.
    - load -> RESP. Load data is formatted from the captured word: select lane, then sign/zero extend to 32 bits.
    - sub-word store -> WRITE.
  - WRITE:
    - mem_write=1 for exactly this cycle; mem_addr = word index.
    - mem_wdata: word store = req_wdata; byte store = captured word with the addressed lane replaced by wdata[7:0]; halfword store = captured word with lanes {1,0} or {3,2} replaced by wdata[15:0].
    - -> RESP.
  - RESP: resp_valid=1, then -> IDLE. A new request can be accepted in the cycle after RESP.
- Latency, accept edge to resp_valid high:
  - load 2 cycles (READ, RESP);
  - word store 2 cycles (WRITE, RESP);
  - sub-word store 3 cycles (READ, WRITE, RESP);
  - error 1 cycle (RESP).
- Outside WRITE, mem_write=0. mem_addr holds its last value in IDLE.
- resp_rdata and resp_error are registered and meaningful only while resp_valid=1. Both are held 0 outside RESP.

Test Plan:
- Reset, then word store addr=0x10 data=0xDEADBEEF, then word load addr=0x10 -> mem_write pulses once with mem_addr=4; load resp_rdata=0xDEADBEEF, resp_error=0, 2 cycles from accept.
- Word 4 = 0xDEADBEEF, byte loads at 0x13 signed and 0x13 unsigned -> 0xFFFFFFDE and 0x000000DE; halfword signed load at 0x10 -> 0xFFFFBEEF.
- Byte store addr=0x11 wdata=0x000000AA over 0xDEADBEEF -> RAM word 4 = 0xDEADAAEF, 3-cycle latency; halfword store addr=0x12 wdata=0x1234 -> 0x1234AAEF.
- Misaligned word load addr=0x02, halfword store addr=0x05, size=11 -> each gives resp_error=1 and resp_rdata=0 one cycle after accept; mem_write stays 0; RAM unchanged.
- req_valid held high with back-to-back requests -> req_ready low from accept through RESP; no request lost or duplicated; responses in order.
- rst_n low during READ of a byte store -> no mem_write, no resp_valid; target word unchanged; req_ready=1 the cycle after release; addr=0x410 with ADDR_WIDTH=8 aliases to word 4.
